// File: rtl/menu_link_controller_if.sv
// Menu-side signal bundle for menu_link_controller: mouse and peer inputs, link/game outputs.
// The controller takes the slave modport; whoever drives the mouse and peer takes master.
interface menu_link_controller_if;
  logic MOUSE_LEFT;
  logic mouse_on_start_button;
  logic mouse_on_connect_button;
  logic peer_connect_in;
  logic peer_start_in;
  logic game_over;
  logic send_connect;
  logic receive_connect;
  logic start_game;
  logic two_player;
  logic menu_active;

  modport slave (
    input  MOUSE_LEFT, mouse_on_start_button, mouse_on_connect_button,
    input  peer_connect_in, peer_start_in, game_over,
    output send_connect, receive_connect, start_game, two_player, menu_active
  );

  modport master (
    output MOUSE_LEFT, mouse_on_start_button, mouse_on_connect_button,
    output peer_connect_in, peer_start_in, game_over,
    input  send_connect, receive_connect, start_game, two_player, menu_active
  );
endinterface

// File: rtl/menu_link_controller.sv
// Menu / two-board link handshake controller with registered outputs and a connect timeout.
// Define MENU_CLICK_RELEASE_EN to fire clicks on button release instead of press.
module menu_link_controller #(
  parameter int TIMEOUT_CYC = 200000000,
  parameter int CNT_W       = 28
) (
  input  logic                   clk,
  input  logic                   rst_n,
  menu_link_controller_if.slave  bus,
  output logic [2:0]             state_dbg
);

  typedef enum logic [2:0] {IDLE, REQ, RCV, LINKED, START, PLAY} state_t;

  state_t           state_q, state_n;
  logic [CNT_W-1:0] timer_q, timer_n;
  logic             pc_m, pc_s, pc_d, ps_m, ps_s, ps_d;
  logic             ml_d;
  logic             send_n, recv_n, start_n, tp_n, menu_n;
  logic             start_click, connect_click;
  logic             pc_rise, ps_rise, timeout;

  // Peer levels are asynchronous: two flops to resolve metastability, a third for edges.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_m <= 1'b0; pc_s <= 1'b0; pc_d <= 1'b0;
      ps_m <= 1'b0; ps_s <= 1'b0; ps_d <= 1'b0;
      ml_d <= 1'b0;
    end else begin
      pc_m <= bus.peer_connect_in; pc_s <= pc_m; pc_d <= pc_s;
      ps_m <= bus.peer_start_in;   ps_s <= ps_m; ps_d <= ps_s;
      ml_d <= bus.MOUSE_LEFT;
    end
  end

  assign pc_rise = pc_s & ~pc_d;
  assign ps_rise = ps_s & ~ps_d;
  assign timeout = (timer_q == CNT_W'(TIMEOUT_CYC - 1));

`ifdef MENU_CLICK_RELEASE_EN
  logic arm_start_q, arm_connect_q;
  logic rel_edge;

  assign rel_edge = ~bus.MOUSE_LEFT & ml_d;

  // Arm on press over a button; leaving that button while held cancels the click.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      arm_start_q   <= 1'b0;
      arm_connect_q <= 1'b0;
    end else if (bus.MOUSE_LEFT && !ml_d) begin
      arm_start_q   <= bus.mouse_on_start_button;
      arm_connect_q <= bus.mouse_on_connect_button & ~bus.mouse_on_start_button;
    end else if (bus.MOUSE_LEFT) begin
      if (!bus.mouse_on_start_button)   arm_start_q   <= 1'b0;
      if (!bus.mouse_on_connect_button) arm_connect_q <= 1'b0;
    end else begin
      arm_start_q   <= 1'b0;
      arm_connect_q <= 1'b0;
    end
  end

  assign start_click   = rel_edge & arm_start_q & bus.menu_active;
  assign connect_click = rel_edge & arm_connect_q & bus.menu_active;
`else
  logic press_edge;

  assign press_edge    = bus.MOUSE_LEFT & ~ml_d;
  assign start_click   = press_edge & bus.mouse_on_start_button & bus.menu_active;
  assign connect_click = press_edge & bus.mouse_on_connect_button &
                         ~bus.mouse_on_start_button & bus.menu_active;
`endif

  always_comb begin
    state_n = state_q;
    tp_n    = bus.two_player;
    case (state_q)
      IDLE: begin
        if (connect_click && pc_rise)  state_n = LINKED;
        else if (connect_click)        state_n = REQ;
        else if (pc_rise)              state_n = RCV;
        else if (start_click) begin
          state_n = START;
          tp_n    = 1'b0;
        end
      end
      REQ: begin
        if (pc_s)                      state_n = LINKED;
        else if (connect_click)        state_n = IDLE;
        else if (timeout)              state_n = IDLE;
      end
      RCV: begin
        if (!pc_s || timeout)          state_n = IDLE;
        else if (connect_click)        state_n = LINKED;
      end
      LINKED: begin
        // Losing the peer outranks any simultaneous start request.
        if (!pc_s) begin
          state_n = IDLE;
          tp_n    = 1'b0;
        end else if (start_click || ps_rise) begin
          state_n = START;
          tp_n    = 1'b1;
        end
      end
      START:   state_n = PLAY;
      PLAY: begin
        if (bus.game_over) begin
          state_n = IDLE;
          tp_n    = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase

    send_n = 1'b0;
    recv_n = 1'b0;
    case (state_n)
      REQ:         send_n = 1'b1;
      RCV:         recv_n = 1'b1;
      LINKED: begin
        send_n = 1'b1;
        recv_n = 1'b1;
      end
      START, PLAY: begin
        send_n = tp_n;
        recv_n = tp_n;
      end
      default: ;
    endcase
    start_n = (state_n == START);
    menu_n  = !((state_n == START) || (state_n == PLAY));

    timer_n = timer_q;
    if (state_n != state_q)
      timer_n = '0;
    else if (((state_q == REQ) || (state_q == RCV)) && (timer_q != '1))
      timer_n = timer_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q             <= IDLE;
      timer_q             <= '0;
      bus.send_connect    <= 1'b0;
      bus.receive_connect <= 1'b0;
      bus.start_game      <= 1'b0;
      bus.two_player      <= 1'b0;
      bus.menu_active     <= 1'b1;
    end else begin
      state_q             <= state_n;
      timer_q             <= timer_n;
      bus.send_connect    <= send_n;
      bus.receive_connect <= recv_n;
      bus.start_game      <= start_n;
      bus.two_player      <= tp_n;
      bus.menu_active     <= menu_n;
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_menu_link_controller.sv
// Directed bench for menu_link_controller (TIMEOUT_CYC=16): reset, timeout, link flow, corners.
// Outputs compared as {send_connect, receive_connect, start_game, two_player, menu_active}.
module tb_menu_link_controller;
  localparam int TIMEOUT_CYC = 16;
  localparam int CNT_W       = 5;

  // Input field order: {MOUSE_LEFT, on_start, on_connect, peer_connect, peer_start, game_over}
  localparam logic [5:0] NONE = 6'b000000;
  localparam logic [5:0] ML   = 6'b100000;
  localparam logic [5:0] OS   = 6'b010000;
  localparam logic [5:0] OC   = 6'b001000;
  localparam logic [5:0] PC   = 6'b000100;
  localparam logic [5:0] PS   = 6'b000010;
  localparam logic [5:0] GO   = 6'b000001;

  typedef struct {
    logic [5:0] in;
    logic [4:0] exp;
    string      name;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] state_dbg;
  int         checks = 0;
  int         failures = 0;
  logic [4:0] exp_q[$];
  vec_t       vecs[$];

  menu_link_controller_if bus();

  menu_link_controller #(.TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [5:0] in);
    {bus.MOUSE_LEFT, bus.mouse_on_start_button, bus.mouse_on_connect_button,
     bus.peer_connect_in, bus.peer_start_in, bus.game_over} = in;
  endtask

  task automatic compare(input string name);
    logic [4:0] got;
    logic [4:0] e;
    got = {bus.send_connect, bus.receive_connect, bus.start_game, bus.two_player, bus.menu_active};
    e   = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, got, e, $time);
    end
  endtask

  // Drive one cycle of inputs away from the edge, check registered outputs just after it.
  task automatic step(input logic [5:0] in, input logic [4:0] exp, input string name);
    @(negedge clk);
    drive(in);
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    compare(name);
  endtask

  initial begin
    drive(NONE);
    rst_n = 1'b0;
    step(NONE, 5'b00001, "reset_0");
    step(NONE, 5'b00001, "reset_1");
    rst_n = 1'b1;
    step(NONE, 5'b00001, "idle_after_reset");

`ifdef MENU_CLICK_RELEASE_EN
    step(ML | OC, 5'b00001, "rel_press_arm");
    step(ML,      5'b00001, "rel_move_off");
    step(NONE,    5'b00001, "rel_release_off");
    step(ML | OC, 5'b00001, "rel_press");
    step(ML | OC, 5'b00001, "rel_hold");
    step(OC,      5'b10001, "rel_fire_req");
`else
    step(ML | OC, 5'b10001, "req_entry");
`endif
    step(NONE, 5'b10001, "req_wait");
    for (int k = 2; k <= TIMEOUT_CYC; k++)
      step(NONE, (k < TIMEOUT_CYC) ? 5'b10001 : 5'b00001, "req_timeout");
    step(NONE, 5'b00001, "idle_after_timeout");

`ifndef MENU_CLICK_RELEASE_EN
    vecs.push_back('{PC,           5'b00001, "pc_sync1"});
    vecs.push_back('{PC,           5'b00001, "pc_sync2"});
    vecs.push_back('{PC,           5'b01001, "rcv_entry"});
    vecs.push_back('{PC | ML | OC, 5'b11001, "rcv_to_linked"});
    vecs.push_back('{PC,           5'b11001, "linked_hold"});
    vecs.push_back('{PC | ML | OS, 5'b11110, "start_2p"});
    vecs.push_back('{PC,           5'b11010, "play_2p"});
    vecs.push_back('{PC | ML | OS, 5'b11010, "play_click_ignored"});
    vecs.push_back('{PC | GO,      5'b00001, "game_over_2p"});
    vecs.push_back('{PC,           5'b00001, "idle_pc_level"});
    vecs.push_back('{PC | ML | OC, 5'b10001, "req_again"});
    vecs.push_back('{PC,           5'b11001, "req_to_linked"});
    vecs.push_back('{PS,           5'b11001, "drop_sync1"});
    vecs.push_back('{PS,           5'b11001, "drop_sync2"});
    vecs.push_back('{PS,           5'b00001, "drop_wins_start"});
    vecs.push_back('{PS,           5'b00001, "idle_no_start"});
    vecs.push_back('{PS | ML | OS, 5'b00100, "start_1p"});
    vecs.push_back('{NONE,         5'b00000, "play_1p"});
    vecs.push_back('{GO,           5'b00001, "game_over_1p"});
    vecs.push_back('{PC,           5'b00001, "pc2_sync1"});
    vecs.push_back('{PC,           5'b00001, "pc2_sync2"});
    vecs.push_back('{PC,           5'b01001, "rcv2_entry"});
    vecs.push_back('{PC | ML | OS, 5'b01001, "rcv_start_ignored"});
    vecs.push_back('{NONE,         5'b01001, "rcv_drop_sync1"});
    vecs.push_back('{NONE,         5'b01001, "rcv_drop_sync2"});
    vecs.push_back('{NONE,         5'b00001, "rcv_drop_idle"});
    vecs.push_back('{ML | OC,      5'b10001, "req3_entry"});
    vecs.push_back('{NONE,         5'b10001, "req3_hold"});
    vecs.push_back('{ML | OC,      5'b00001, "req_cancel"});
    vecs.push_back('{NONE,         5'b00001, "idle_after_cancel"});
    vecs.push_back('{PC,           5'b00001, "pc3_sync1"});
    vecs.push_back('{PC,           5'b00001, "pc3_sync2"});
    vecs.push_back('{PC | ML | OC, 5'b11001, "both_to_linked"});
    vecs.push_back('{NONE,         5'b11001, "linked_drop_sync1"});
    vecs.push_back('{NONE,         5'b11001, "linked_drop_sync2"});
    vecs.push_back('{NONE,         5'b00001, "linked_drop_idle"});

    foreach (vecs[i])
      step(vecs[i].in, vecs[i].exp, vecs[i].name);

    // Reset taken in the middle of a game must restore the menu defaults.
    step(ML | OS, 5'b00100, "start_before_reset");
    step(NONE,    5'b00000, "play_before_reset");
    rst_n = 1'b0;
    step(NONE,    5'b00001, "reset_in_play");
    rst_n = 1'b1;
    step(NONE,    5'b00001, "idle_after_play_reset");
    step(ML | OC, 5'b10001, "click_after_reset");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/menu_link_controller.md
MENU_LINK_CONTROLLER -- requirements
Module: menu_link_controller

Interface
REQ-001 The module SHALL have a parameter TIMEOUT_CYC, default 200000000, giving the connect-request timeout in clk cycles (2 s at 100 MHz).
REQ-002 The module SHALL have a parameter CNT_W, default 28, giving the timeout counter width; it SHALL satisfy 2^CNT_W > TIMEOUT_CYC.
REQ-003 The module SHALL have an input port clk, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The module SHALL have an input port rst_n, 1 bit: reset, synchronous, active-low.
REQ-005 The module SHALL have an input port MOUSE_LEFT, 1 bit: left mouse button level, synchronous to clk.
REQ-006 The module SHALL have input ports mouse_on_start_button and mouse_on_connect_button, 1 bit each: cursor inside the respective button.
REQ-007 The module SHALL have input ports peer_connect_in and peer_start_in, 1 bit each: asynchronous levels from the peer board.
REQ-008 The module SHALL have an input port game_over, 1 bit: a one-cycle pulse from game logic.
REQ-009 The module SHALL have output ports send_connect and receive_connect, 1 bit each: menu link status, driven to the menu pixel generator and the peer.
REQ-010 The module SHALL have an output port start_game, 1 bit: a one-cycle start pulse.
REQ-011 The module SHALL have output ports two_player and menu_active, 1 bit each: game mode; menu screen selected.

Function
REQ-012 peer_connect_in and peer_start_in SHALL each pass through a 2-flop synchronizer; only the synchronized values (pc_s, ps_s) SHALL be used, and edges SHALL be taken from a third register.
REQ-013 A click event SHALL be MOUSE_LEFT 0->1 (previous-cycle register) with the button's mouse_on_* high in that same cycle; start_click and connect_click are mutually exclusive.
REQ-014 The FSM SHALL have the states IDLE, REQ, RCV, LINKED, START and PLAY, with all outputs registered.
REQ-015 IDLE: on connect_click -> REQ; on pc_s rising -> RCV; on both in the same cycle -> LINKED; on start_click with neither -> START with two_player=0.
REQ-016 REQ: send_connect=1; on pc_s=1 -> LINKED; on connect_click (cancel) -> IDLE; on timer==TIMEOUT_CYC-1 -> IDLE.
REQ-017 RCV: receive_connect=1; on connect_click -> LINKED; on pc_s=0 or timeout -> IDLE; start_click SHALL be ignored.
REQ-018 LINKED: send_connect=receive_connect=1; on start_click or ps_s rising -> START with two_player=1; on pc_s=0 -> IDLE with two_player=0; pc_s=0 SHALL win over a simultaneous start.
REQ-019 START: start_game=1 for exactly one cycle, unconditionally -> PLAY; menu_active=0 from START onward.
REQ-020 PLAY: link outputs SHALL hold their LINKED values if two_player; on game_over -> IDLE with menu_active=1, two_player=0 and link outputs 0 in the next cycle.
REQ-021 The timer SHALL clear on every state entry, increment only in REQ and RCV, and saturate rather than wrap.
REQ-022 The latency from a qualifying input (post-synchronizer for peer signals) to the state and outputs SHALL be 1 cycle.
REQ-023 Clicks while menu_active=0 SHALL be ignored.

Reset
REQ-024 On rst_n=0 at a clk edge, state SHALL be IDLE and the timer and edge registers 0, including mid-operation.
REQ-025 On rst_n=0, send_connect, receive_connect, start_game and two_player SHALL be 0 and menu_active SHALL be 1.
REQ-026 On rst_n=0, the synchronizer flops SHALL be 0.

Configuration
REQ-027 With MENU_CLICK_RELEASE_EN defined, a click SHALL arm on press over a button, disarm if the cursor leaves that button while held, and fire on the MOUSE_LEFT 1->0 edge if still armed.
REQ-028 With MENU_CLICK_RELEASE_EN undefined, the press-edge rule of REQ-013 SHALL apply and no arm register SHALL exist.

Verification (TIMEOUT_CYC=16)
REQ-029 Reset, then connect_click -> REQ, send_connect=1; with no peer, send_connect=0 exactly 16 cycles after entry.
REQ-030 Raise peer_connect_in -> receive_connect=1 3 cycles later; connect_click -> both link outputs=1; start_click -> one start_game pulse, two_player=1, menu_active=0.
REQ-031 In LINKED, drop peer_connect_in and raise peer_start_in together -> return to IDLE, no start_game pulse.
REQ-032 In IDLE, start_click -> start_game pulse, two_player=0; game_over -> menu_active=1 next cycle.
REQ-033 Assert rst_n=0 in PLAY -> next cycle all outputs 0 except menu_active=1.
REQ-034 With MENU_CLICK_RELEASE_EN defined: press over the connect button, move off, release -> no transition; press and release over it -> REQ on the release cycle+1.
